// File: rtl/led_scan_driver_if.sv
// Bus between the frame source and the LED scan driver: enable and pixel frames in,
// row/column drive and frame status out.
interface led_scan_driver_if;
   logic              Enable;
   logic [15:0][15:0] RedPixels;
   logic [15:0][15:0] GrnPixels;
   logic [15:0]       RowSel;
   logic [15:0]       RedCol;
   logic [15:0]       GrnCol;
   logic [3:0]        RowIdx;
   logic              FrameDone;

   modport master (
      output Enable, RedPixels, GrnPixels,
      input  RowSel, RedCol, GrnCol, RowIdx, FrameDone
   );

   modport slave (
      input  Enable, RedPixels, GrnPixels,
      output RowSel, RedCol, GrnCol, RowIdx, FrameDone
   );
endinterface

// File: rtl/led_scan_driver.sv
// Row-multiplexed 16x16 bicolour LED scanner: latches a whole frame, then walks the rows
// with a blanking gap before each one so adjacent rows never overlap.
module led_scan_driver #(
   parameter int DWELL = 64,
   parameter int BLANK = 4
) (
   input logic             CLK,
   input logic             RST,
   led_scan_driver_if.slave bus
);

   localparam int MAXP = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXP + 1);

   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t DWELL_LOAD = cnt_t'(DWELL - 1);
   localparam cnt_t BLANK_LOAD = cnt_t'(BLANK - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BLANK, ST_DRIVE} state_t;

   state_t            state, state_next;
   logic [3:0]        row, row_next;
   cnt_t              cnt, cnt_next;
   logic              frame_done, frame_done_next;
   logic [15:0][15:0] shadow_red, shadow_grn;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         row        <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         row        <= row_next;
         cnt        <= cnt_next;
         frame_done <= frame_done_next;
      end
   end

   // The frame is only sampled in LOAD, so the scan always shows one coherent image.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shadow_red <= '0;
         shadow_grn <= '0;
      end else if (state == ST_LOAD) begin
         shadow_red <= bus.RedPixels;
         shadow_grn <= bus.GrnPixels;
      end
   end

   always_comb begin
      state_next      = state;
      row_next        = row;
      cnt_next        = cnt;
      frame_done_next = 1'b0;
      if (!bus.Enable) begin
         state_next = ST_IDLE;
         row_next   = '0;
         cnt_next   = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_next = ST_LOAD;
               row_next   = '0;
               cnt_next   = '0;
            end
            ST_LOAD: begin
               state_next = ST_BLANK;
               row_next   = '0;
               cnt_next   = BLANK_LOAD;
            end
            ST_BLANK: begin
               if (cnt == '0) begin
                  state_next = ST_DRIVE;
                  cnt_next   = DWELL_LOAD;
               end else begin
                  cnt_next = cnt - cnt_t'(1);
               end
            end
            ST_DRIVE: begin
               if (cnt == '0) begin
                  if (row == 4'd15) begin
                     state_next      = ST_LOAD;
                     row_next        = '0;
                     cnt_next        = '0;
                     frame_done_next = 1'b1;
                  end else begin
                     state_next = ST_BLANK;
                     row_next   = row + 4'd1;
                     cnt_next   = BLANK_LOAD;
                  end
               end else begin
                  cnt_next = cnt - cnt_t'(1);
               end
            end
            default: begin
               state_next = ST_IDLE;
               row_next   = '0;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; every non-DRIVE state blanks the matrix.
   always_comb begin
      bus.RowSel = '0;
      bus.RedCol = '0;
      bus.GrnCol = '0;
      bus.RowIdx = '0;
      if (state == ST_DRIVE) begin
         bus.RowSel = 16'd1 << row;
         bus.RedCol = shadow_red[row];
         bus.GrnCol = shadow_grn[row];
      end
      if (state == ST_BLANK || state == ST_DRIVE) begin
         bus.RowIdx = row;
      end
   end

   assign bus.FrameDone = frame_done;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: two instances (DWELL=4/BLANK=2 and DWELL=1/BLANK=1) checked
// every cycle against a frame-position model, plus directed literal expectations.
module tb_led_scan_driver;

   logic CLK;
   logic RST;

   led_scan_driver_if ifa ();
   led_scan_driver_if ifb ();

   led_scan_driver #(.DWELL(4), .BLANK(2)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
   led_scan_driver #(.DWELL(1), .BLANK(1)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model: a scanning instance is fully described by its position since the last LOAD.
   int                m_b   [2] = '{2, 1};
   int                m_d   [2] = '{4, 1};
   bit                m_act [2] = '{0, 0};
   int                m_pos [2] = '{0, 0};
   bit                m_fd  [2] = '{0, 0};
   logic [15:0][15:0] m_red [2];
   logic [15:0][15:0] m_grn [2];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelStep(input int k, input logic en, input logic [15:0][15:0] red,
                            input logic [15:0][15:0] grn);
      int period;
      period = 1 + 16 * (m_b[k] + m_d[k]);
      if (RST || !en) begin
         m_act[k] = 0;
         m_pos[k] = 0;
         m_fd[k]  = 0;
      end else if (!m_act[k]) begin
         m_act[k] = 1;
         m_pos[k] = 0;
         m_fd[k]  = 0;
      end else begin
         if (m_pos[k] == 0) begin
            m_red[k] = red;
            m_grn[k] = grn;
         end
         m_pos[k] = m_pos[k] + 1;
         m_fd[k]  = 0;
         if (m_pos[k] == period) begin
            m_pos[k] = 0;
            m_fd[k]  = 1;
         end
      end
   endtask

   always @(posedge CLK or posedge RST) begin
      modelStep(0, ifa.Enable, ifa.RedPixels, ifa.GrnPixels);
      modelStep(1, ifb.Enable, ifb.RedPixels, ifb.GrnPixels);
   end

   task automatic expectOut(input int k, output logic [15:0] rs, output logic [15:0] rc,
                            output logic [15:0] gc, output logic [3:0] ri, output logic fd);
      int kk, r, off;
      rs = '0; rc = '0; gc = '0; ri = '0; fd = 1'b0;
      if (m_act[k]) begin
         if (m_pos[k] == 0) begin
            fd = m_fd[k];
         end else begin
            kk  = m_pos[k] - 1;
            r   = kk / (m_b[k] + m_d[k]);
            off = kk % (m_b[k] + m_d[k]);
            ri  = 4'(r);
            if (off >= m_b[k]) begin
               rs = 16'd1 << r;
               rc = m_red[k][r];
               gc = m_grn[k][r];
            end
         end
      end
   endtask

   task automatic compareInst(input int k, input string name, input logic [15:0] rs,
                              input logic [15:0] rc, input logic [15:0] gc,
                              input logic [3:0] ri, input logic fd);
      logic [15:0] ers, erc, egc;
      logic [3:0]  eri;
      logic        efd;
      expectOut(k, ers, erc, egc, eri, efd);
      checkOutput({name, "_outputs"}, {11'd0, rs, rc, gc, ri, fd}, {11'd0, ers, erc, egc, eri, efd});
      checkOutput({name, "_rowsel_onehot0"}, {63'd0, $onehot0(rs)}, 64'd1);
      checkOutput({name, "_cols_off_when_blank"}, {32'd0, (rs == 16'd0) ? {rc, gc} : 32'd0}, 64'd0);
   endtask

   always @(negedge CLK) begin
      compareInst(0, "a", ifa.RowSel, ifa.RedCol, ifa.GrnCol, ifa.RowIdx, ifa.FrameDone);
      compareInst(1, "b", ifb.RowSel, ifb.RedCol, ifb.GrnCol, ifb.RowIdx, ifb.FrameDone);
   end

   task automatic waitEdge();
      @(posedge CLK);
      #1;
   endtask

   task automatic setEnable(input logic v);
      ifa.Enable = v;
      ifb.Enable = v;
   endtask

   task automatic randomFrame(output logic [15:0][15:0] f);
      for (int r = 0; r < 16; r++) f[r] = 16'($urandom);
   endtask

   task automatic applyStimulus();
      logic [15:0][15:0] f;
      waitEdge();
      if ($urandom_range(0, 7) == 0) begin randomFrame(f); ifa.RedPixels = f; end
      if ($urandom_range(0, 7) == 0) begin randomFrame(f); ifa.GrnPixels = f; end
      if ($urandom_range(0, 7) == 0) begin randomFrame(f); ifb.RedPixels = f; end
      if ($urandom_range(0, 7) == 0) begin randomFrame(f); ifb.GrnPixels = f; end
      if (ifa.Enable) begin
         if ($urandom_range(0, 399) == 0) setEnable(1'b0);
      end else if ($urandom_range(0, 3) == 0) begin
         setEnable(1'b1);
      end
      if ($urandom_range(0, 799) == 0) begin
         #2;
         RST = 1'b1;
         waitEdge();
         waitEdge();
         RST = 1'b0;
      end
   endtask

   initial begin
      int fd_a_first, fd_b_first, fd_b_second;
      RST = 1'b0;
      setEnable(1'b0);
      ifa.RedPixels = '0; ifa.GrnPixels = '0;
      ifb.RedPixels = '0; ifb.GrnPixels = '0;
      #1 RST = 1'b1;
      #2;
      checkOutput("reset_a", {11'd0, ifa.RowSel, ifa.RedCol, ifa.GrnCol, ifa.RowIdx, ifa.FrameDone}, 64'd0);
      checkOutput("reset_b", {11'd0, ifb.RowSel, ifb.RedCol, ifb.GrnCol, ifb.RowIdx, ifb.FrameDone}, 64'd0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (2) waitEdge();
      checkOutput("idle_before_enable", {43'd0, ifa.RowSel, ifa.RowIdx, ifa.FrameDone}, 64'd0);

      // Basic scan with a diagonal red pattern on A and a solid frame on B.
      for (int r = 0; r < 16; r++) ifa.RedPixels[r] = 16'd1 << r;
      ifb.RedPixels = '1;
      ifb.GrnPixels = '1;
      setEnable(1'b1);
      fd_a_first = 0; fd_b_first = 0; fd_b_second = 0;
      for (int i = 1; i <= 260; i++) begin
         waitEdge();
         if (ifa.FrameDone && fd_a_first == 0) fd_a_first = i;
         if (ifb.FrameDone) begin
            if (fd_b_first == 0) fd_b_first = i;
            else if (fd_b_second == 0) fd_b_second = i;
         end
         if (i == 20) checkOutput("a_row3_blank", {44'd0, ifa.RowSel, ifa.RowIdx}, {44'd0, 16'h0000, 4'd3});
         if (i == 22) checkOutput("a_row3_drive", {12'd0, ifa.RowSel, ifa.RedCol, ifa.GrnCol, ifa.RowIdx},
                                  {12'd0, 16'h0008, 16'h0008, 16'h0000, 4'd3});
         if (i == 133) ifa.RedPixels = '1;
         if (i == 137) checkOutput("a_tear_free_row6", {48'd0, ifa.RedCol}, {48'd0, 16'h0040});
         if (i == 198) checkOutput("a_new_frame_row0", {32'd0, ifa.RowSel, ifa.RedCol}, {32'd0, 16'h0001, 16'hFFFF});
      end
      checkOutput("a_frame_done_cycle", 64'(fd_a_first), 64'd98);
      checkOutput("b_frame_done_cycle", 64'(fd_b_first), 64'd34);
      checkOutput("b_frame_period", 64'(fd_b_second - fd_b_first), 64'd33);

      // Mid-frame abort during row 7 blanking, then restart from row 0.
      setEnable(1'b0);
      RST = 1'b1;
      repeat (2) waitEdge();
      RST = 1'b0;
      waitEdge();
      setEnable(1'b1);
      repeat (44) waitEdge();
      checkOutput("a_row7_blank", {44'd0, ifa.RowSel, ifa.RowIdx}, {44'd0, 16'h0000, 4'd7});
      setEnable(1'b0);
      waitEdge();
      checkOutput("a_abort_idle", {11'd0, ifa.RowSel, ifa.RedCol, ifa.GrnCol, ifa.RowIdx, ifa.FrameDone}, 64'd0);
      setEnable(1'b1);
      waitEdge();
      checkOutput("a_no_fd_on_restart", {63'd0, ifa.FrameDone}, 64'd0);
      repeat (3) waitEdge();
      checkOutput("a_restart_row0", {44'd0, ifa.RowSel, ifa.RowIdx}, {44'd0, 16'h0001, 4'd0});

      // Asynchronous reset between edges while A is driving.
      #2 RST = 1'b1;
      #1;
      checkOutput("a_async_reset", {28'd0, ifa.RowSel, ifa.RedCol, ifa.RowIdx}, 64'd0);
      checkOutput("b_async_reset", {28'd0, ifb.RowSel, ifb.RedCol, ifb.RowIdx}, 64'd0);
      setEnable(1'b0);
      repeat (2) waitEdge();
      RST = 1'b0;
      repeat (3) waitEdge();
      checkOutput("a_idle_hold", {43'd0, ifa.RowSel, ifa.RowIdx, ifa.FrameDone}, 64'd0);
      setEnable(1'b1);

      repeat (3000) applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 SHALL have parameter DWELL, default 64, giving the cycles each row is driven (legal range 1..1024).
REQ-002 SHALL have parameter BLANK, default 4, giving the all-off cycles before each row (legal range 1..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port Enable, input, 1 bit: scan enable.
REQ-006 SHALL have port RedPixels, input, [15:0][15:0]: red frame, indexed [row][col].
REQ-007 SHALL have port GrnPixels, input, [15:0][15:0]: green frame, indexed [row][col].
REQ-008 SHALL have port RowSel, output, 16 bits: one-hot active-high row drive.
REQ-009 SHALL have port RedCol, output, 16 bits: red column drive for the active row.
REQ-010 SHALL have port GrnCol, output, 16 bits: green column drive for the active row.
REQ-011 SHALL have port RowIdx, output, 4 bits: index of the current row.
REQ-012 SHALL have port FrameDone, output, 1 bit: single-cycle pulse at completion of a full frame.

Function
REQ-013 SHALL implement four states: IDLE, LOAD, BLANK and DRIVE.
REQ-014 SHALL make every output a function of registered state only, with no combinational path from any input to any output.
REQ-015 SHALL, in IDLE, go to LOAD on the next edge if Enable=1, and otherwise stay in IDLE.
REQ-016 SHALL, in LOAD (1 cycle), capture RedPixels and GrnPixels into shadow registers, set the row to 0, and go to BLANK.
REQ-017 SHALL, in BLANK, hold for exactly BLANK cycles and then go to DRIVE.
REQ-018 SHALL, in DRIVE, hold for exactly DWELL cycles; then, if row<15, increment the row and go to BLANK, and if row=15, go to LOAD.
REQ-019 SHALL, during DRIVE, set RowSel[r]=1 for the current row r, with all other RowSel bits 0.
REQ-020 SHALL, during DRIVE, set RedCol[c]=shadowRed[r][c] and GrnCol[c]=shadowGrn[r][c].
REQ-021 SHALL, in IDLE, LOAD and BLANK, drive RowSel, RedCol and GrnCol to 0 (break-before-make between rows).
REQ-022 SHALL ignore input pixel changes between LOAD cycles, so a frame is never torn mid-scan.
REQ-023 SHALL make RowIdx equal the current row in BLANK and DRIVE, and 0 in IDLE and LOAD.
REQ-024 SHALL assert FrameDone for exactly one cycle: the LOAD cycle entered from row-15 DRIVE.
REQ-025 SHALL NOT assert FrameDone on a LOAD entered from IDLE.
REQ-026 SHALL give a frame period of 1 + 16*(BLANK+DWELL) cycles while Enable stays 1.
REQ-027 SHALL size the dwell and blank counters to hold the maximum legal parameter value without overflow.
REQ-028 SHALL reload the dwell and blank counters on every state entry.
REQ-029 SHALL, when Enable=0 in any state, enter IDLE on the next edge and clear the row; the partial frame is aborted and FrameDone is not asserted.
REQ-030 SHALL give Enable=0 priority over every other transition when both apply in the same cycle.
REQ-031 SHALL, when Enable is reasserted after an abort, restart with LOAD and row 0, never resuming mid-frame.

Reset
REQ-032 SHALL, while RST=1, immediately and without waiting for a clock edge force state=IDLE, row=0, counters=0, shadow registers=0, RowSel=0, RedCol=0, GrnCol=0, RowIdx=0 and FrameDone=0.
REQ-033 SHALL, after RST deasserts, stay in IDLE until the first edge at which Enable=1.
REQ-034 SHALL, on RST asserted mid-frame, discard the frame; the next Enable gives a fresh LOAD.

Verification
REQ-035 SHALL cover the following directed scenarios, with DWELL=4 and BLANK=2:
- Basic scan: RST pulse, Enable=1, RedPixels[r]=16'h0001<<r, GrnPixels=0 -> for each r, 2 zero cycles, then 4 cycles of RowSel=1<<r and RedCol=1<<r; FrameDone pulses on cycle 97 after LOAD; then repeats.
- Tear-free capture: change RedPixels to all-ones during row 5 DRIVE -> rows 5..15 still show the old frame; the new frame appears only after the next LOAD.
- Mid-frame abort: drop Enable during row 7 BLANK -> next cycle IDLE with all outputs 0 and no FrameDone; reassert Enable -> LOAD, then row 0.
- Async reset: assert RST mid-DRIVE between clock edges -> outputs go to 0 before the next edge; after release, IDLE is held until Enable=1.
- Minimum timing: DWELL=1, BLANK=1, all pixels 1 -> RowSel walks one-hot, alternating blank and drive cycles; frame period 33 cycles; RowSel never has two bits set; RowSel is 0 on every blank cycle.
- Checker: assert on every cycle that RowSel is one-hot or zero, and that RedCol=GrnCol=0 whenever RowSel=0.
